// File: rtl/div_taint_pkg.sv
// Shared definitions for the word-taint-tracking restoring divider:
// FSM state encoding, default operand width and the iteration-counter width.
package div_taint_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // The counter must be able to represent WIDTH itself.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_datapath_taint_track_word.sv
// Restoring shift/subtract datapath with a single word-level taint bit that
// follows the quotient/remainder pair.
module divider_datapath_taint_track_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_start_t,
  input  logic             i_dividend_t,
  input  logic             i_divisor_t,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_result_t
);

  // Partial remainder is one bit wider than the operands so the shifted
  // value never overflows before the trial subtraction.
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_res_t;

  logic [WIDTH+1:0] w_shift;
  logic             w_fit;
  logic [WIDTH:0]   w_next_rem;

  // r_quo starts as the dividend; its MSB feeds the remainder each step
  // while quotient bits enter at the LSB.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_fit      = (w_shift >= {2'b00, r_div});
  assign w_next_rem = w_fit ? (w_shift[WIDTH:0] - {1'b0, r_div}) : w_shift[WIDTH:0];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_res_t <= 1'b0;
    end else if (i_load) begin
      r_rem   <= '0;
      r_quo   <= i_dividend;
      r_div   <= i_divisor;
      r_res_t <= i_start_t | i_dividend_t | i_divisor_t;
    end else if (i_step) begin
      r_rem   <= w_next_rem;
      r_quo   <= {r_quo[WIDTH-2:0], w_fit};
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem[WIDTH-1:0];
  assign o_result_t  = r_res_t;

endmodule

// File: rtl/divider_taint_track_word.sv
// Fixed-latency restoring divider (IDLE/LOAD/ITER/DONE) with word-level taint;
// control taint comes only from start_t because timing ignores operand values.
module divider_taint_track_word
  import div_taint_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic             dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_t,
  output logic             busy,
  output logic             busy_t,
  output logic             quotientDone,
  output logic             quotientDone_t
);

  localparam int CNT_W = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_start_t_lat;

  logic w_accept;
  logic w_step;

  // Operands and their taints are captured on the edge that accepts start.
  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_step   = (r_state == ST_ITER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_start_t_lat <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_LOAD;
            r_busy        <= 1'b1;
            r_start_t_lat <= start_t;
            r_cnt         <= '0;
          end
        end
        ST_LOAD: begin
          r_state <= ST_ITER;
          r_cnt   <= '0;
        end
        ST_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
          r_start_t_lat <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  divider_datapath_taint_track_word #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (clk),
    .i_rst_n      (rst),
    .i_load       (w_accept),
    .i_step       (w_step),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .i_start_t    (start_t),
    .i_dividend_t (dividend_t),
    .i_divisor_t  (divisor_t),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_result_t   (result_t)
  );

  assign busy           = r_busy;
  assign quotientDone   = r_done;
  assign busy_t         = r_start_t_lat;
  assign quotientDone_t = r_start_t_lat;

endmodule

// File: tb/tb_divider_taint_track_word.sv
// Directed bench for divider_taint_track_word with a cycle-level reference model.
module tb_divider_taint_track_word;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start_t;
  logic [W-1:0] dividend;
  logic         dividend_t;
  logic [W-1:0] divisor;
  logic         divisor_t;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         result_t;
  logic         busy;
  logic         busy_t;
  logic         quotientDone;
  logic         quotientDone_t;

  int errors = 0;
  int checks = 0;

  divider_taint_track_word #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_t        (start_t),
    .dividend       (dividend),
    .dividend_t     (dividend_t),
    .divisor        (divisor),
    .divisor_t      (divisor_t),
    .quotient       (quotient),
    .remainder      (remainder),
    .result_t       (result_t),
    .busy           (busy),
    .busy_t         (busy_t),
    .quotientDone   (quotientDone),
    .quotientDone_t (quotientDone_t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(a % b);
  endfunction

  // Model: an accepted request occupies W+2 cycles (LOAD, W iterations, DONE);
  // the last of them carries the done pulse and the new result.
  logic         m_active;
  int           m_age;
  logic         m_st;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic         m_rt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_st     <= 1'b0;
      m_q      <= '0;
      m_r      <= '0;
      m_rt     <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_st     <= start_t;
        m_q      <= ref_q(dividend, divisor);
        m_r      <= ref_r(dividend, divisor);
        m_rt     <= start_t | dividend_t | divisor_t;
      end
    end else if (m_age == W + 1) begin
      m_active <= 1'b0;
      m_st     <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cmp_busy", 32'(busy), 32'(m_active));
      chk("cmp_done", 32'(quotientDone), 32'(m_active && m_age == W + 1));
      chk("cmp_busy_t", 32'(busy_t), 32'(m_active & m_st));
      chk("cmp_done_t", 32'(quotientDone_t), 32'(m_active & m_st));
      if (!m_active || m_age == W + 1) begin
        chk("cmp_quotient", 32'(quotient), 32'(m_q));
        chk("cmp_remainder", 32'(remainder), 32'(m_r));
        chk("cmp_result_t", 32'(result_t), 32'(m_rt));
      end
    end
  end

  // One division with hand-computed expectations; inj>0 re-pulses start
  // with 50/5 in that sample slot to show it is ignored.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic at, input logic bt, input logic st,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ert, input logic ebt, input int inj);
    int first;
    int npulse;
    first  = 0;
    npulse = 0;
    @(negedge clk);
    dividend   = a;
    divisor    = b;
    dividend_t = at;
    divisor_t  = bt;
    start_t    = st;
    start      = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= W + 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start   = 1'b0;
        start_t = 1'b0;
      end
      if (inj != 0 && k == inj) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (inj != 0 && k == inj + 1) start = 1'b0;
      if (quotientDone) begin
        if (first == 0) first = k;
        npulse++;
      end
      if (k == 2) begin
        chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
        chk({tag, "_busy_t_mid"}, 32'(busy_t), 32'(ebt));
      end
      if (k == W + 2) chk({tag, "_done_t"}, 32'(quotientDone_t), 32'(ebt));
    end
    chk({tag, "_done_edge"}, 32'(first), 32'(W + 2));
    chk({tag, "_done_count"}, 32'(npulse), 32'd1);
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_result_t"}, 32'(result_t), 32'(ert));
    chk({tag, "_busy_t_idle"}, 32'(busy_t), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int npulse;
    rst        = 1'b1;
    start      = 1'b0;
    start_t    = 1'b0;
    dividend   = '0;
    dividend_t = 1'b0;
    divisor    = '0;
    divisor_t  = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(quotientDone), 32'd0);
    chk("reset_taints", 32'({result_t, busy_t, quotientDone_t}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 1'b0, 1'b0, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0, 0);
    run_div("d37_0", 8'd37, 8'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'd37, 1'b0, 1'b0, 0);
    run_div("d255_1", 8'd255, 8'd1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 1'b1, 1'b0, 0);
    run_div("d9_3", 8'd9, 8'd3, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 1'b1, 1'b1, 0);

    // Abort 200/9 while iterating.
    @(negedge clk);
    dividend   = 8'd200;
    divisor    = 8'd9;
    dividend_t = 1'b1;
    divisor_t  = 1'b0;
    start_t    = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    start_t = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(quotientDone), 32'd0);
    chk("abort_taints", 32'({result_t, busy_t, quotientDone_t}), 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    npulse = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (quotientDone) npulse++;
    end
    chk("abort_no_done", 32'(npulse), 32'd0);

    run_div("d200_9", 8'd200, 8'd9, 1'b0, 1'b0, 1'b0, 8'd22, 8'd2, 1'b0, 1'b0, 0);
    run_div("d81_4", 8'd81, 8'd4, 1'b0, 1'b0, 1'b0, 8'd20, 8'd1, 1'b0, 1'b0, 4);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
